tradeoff_job_sequencer: RTL and testbench

//  Job front-end and result back-end for the Tradeoff_28bits solver. Buffers incoming W operands in a

---
 rtl/tradeoff_job_sequencer.sv | 151 +++++++++++++++
 tb/tb_tradeoff_job_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tradeoff_job_sequencer.sv
// Job FIFO, per-job solver restart/capture FSM and valid/ready result port for the Tradeoff_28bits solver.
// Optional TRADEOFF_SEQ_STATS_EN adds out_cycles (RUN cycles per result) and jobs_done (handshake count).
module tradeoff_job_sequencer #(
  parameter int unsigned W_BITS         = 44,
  parameter int unsigned N_BITS         = 29,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32'd100000000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_BITS-1:0] in_w,
  output logic [W_BITS-1:0] sol_w,
  output logic              sol_rst_n,
  input  logic              sol_found,
  input  logic [N_BITS-1:0] sol_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_BITS-1:0] out_w,
  output logic [N_BITS-1:0] out_n,
  output logic              out_timeout,
`ifdef TRADEOFF_SEQ_STATS_EN
  output logic [CNT_W-1:0]  out_cycles,
  output logic [15:0]       jobs_done,
`endif
  output logic              busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW    = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [W_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
  logic [CNT_W-1:0]  run_cnt, run_inc_c;
  logic [W_BITS-1:0] head_c;
  logic              push_c, pop_c, empty_c, full_nx_c;
  logic              hit_c, expire_c, expire_due_c;

  // FIFO bookkeeping; the extra pointer bit separates full from empty
  assign push_c    = in_valid & in_ready;
  assign empty_c   = (wr_ptr == rd_ptr);
  assign head_c    = mem[rd_ptr[PTR_W-1:0]];
  assign wr_ptr_nx = wr_ptr + PW'(push_c);
  assign rd_ptr_nx = rd_ptr + PW'(pop_c);
  assign full_nx_c = (wr_ptr_nx[PTR_W] != rd_ptr_nx[PTR_W]) &&
                     (wr_ptr_nx[PTR_W-1:0] == rd_ptr_nx[PTR_W-1:0]);

  assign run_inc_c    = (run_cnt == {CNT_W{1'b1}}) ? run_cnt : run_cnt + CNT_W'(1);
  assign expire_due_c = (TIMEOUT_CYCLES != 0) && (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Solver is held in reset for the single LOAD cycle of each job
  assign sol_rst_n = rst_n & (state != LOAD);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop_c    = 1'b0;
    hit_c    = 1'b0;
    expire_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_c) begin
          state_nx = LOAD;
          pop_c    = 1'b1;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        // found takes priority over a timeout landing on the same cycle
        if (sol_found) begin
          hit_c    = 1'b1;
          state_nx = DONE;
        end else if (expire_due_c) begin
          expire_c = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          if (!empty_c) begin
            state_nx = LOAD;
            pop_c    = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr[PTR_W-1:0]] <= in_w;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      sol_w       <= '0;
      run_cnt     <= '0;
      out_valid   <= 1'b0;
      out_w       <= '0;
      out_n       <= '0;
      out_timeout <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nx;
      rd_ptr    <= rd_ptr_nx;
      in_ready  <= !full_nx_c;
      busy      <= (state_nx != IDLE) || (wr_ptr_nx != rd_ptr_nx);
      out_valid <= (state_nx == DONE);
      if (pop_c) sol_w <= head_c;
      if (state == LOAD)     run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_inc_c;
      if (hit_c) begin
        out_w       <= sol_w;
        out_n       <= sol_n;
        out_timeout <= 1'b0;
      end else if (expire_c) begin
        out_w       <= sol_w;
        out_n       <= '0;
        out_timeout <= 1'b1;
      end
    end
  end

`ifdef TRADEOFF_SEQ_STATS_EN
  // run_inc_c counts the capturing cycle itself
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_cycles <= '0;
      jobs_done  <= '0;
    end else begin
      if (hit_c || expire_c)      out_cycles <= run_inc_c;
      if (out_valid && out_ready) jobs_done  <= jobs_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tradeoff_job_sequencer.sv
// Bench for tradeoff_job_sequencer: stub solver finds after W[7:0] RUN cycles (0 = never) with N = W[43:15].
// Expected results come from a job-level model; compile with TRADEOFF_SEQ_STATS_EN to also check the stats ports.
module tb_tradeoff_job_sequencer;

  localparam int unsigned WB = 44;
  localparam int unsigned NB = 29;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [WB-1:0] in_w, sol_w;
  logic          sol_rst_n, sol_found;
  logic [NB-1:0] sol_n;
  logic          out_valid, out_ready;
  logic [WB-1:0] out_w;
  logic [NB-1:0] out_n;
  logic          out_timeout, busy;
`ifdef TRADEOFF_SEQ_STATS_EN
  logic [CW-1:0] out_cycles;
  logic [15:0]   jobs_done;
`endif

  tradeoff_job_sequencer #(
    .W_BITS(WB), .N_BITS(NB), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w),
    .sol_w(sol_w), .sol_rst_n(sol_rst_n), .sol_found(sol_found), .sol_n(sol_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_n(out_n),
    .out_timeout(out_timeout),
`ifdef TRADEOFF_SEQ_STATS_EN
    .out_cycles(out_cycles), .jobs_done(jobs_done),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub solver: counts cycles since its reset and stays found once reached
  logic [15:0] srun;
  always @(posedge clk) begin
    if (!sol_rst_n)             srun <= 16'd0;
    else if (srun != 16'hFFFF)  srun <= srun + 16'd1;
  end
  assign sol_found = (sol_w[7:0] != 8'd0) && (srun >= ({8'd0, sol_w[7:0]} - 16'd1));
  assign sol_n     = sol_w[WB-1:WB-NB];

  int unsigned   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [WB-1:0] acc_w[$];
  int unsigned   acc_c[$];
  logic [WB-1:0] plan_q[$];
  int            jobs_model = 0;

  // Job-level reference: found within TO cycles, otherwise a timeout after exactly TO cycles
  function automatic bit found_in_time(input logic [WB-1:0] w);
    int unsigned t;
    t = w[7:0];
    return (t != 0) && (t <= TO);
  endfunction

  function automatic int exp_cyc(input logic [WB-1:0] w);
    int unsigned t;
    t = w[7:0];
    return found_in_time(w) ? int'(t) : int'(TO);
  endfunction

  function automatic logic exp_to(input logic [WB-1:0] w);
    return !found_in_time(w);
  endfunction

  function automatic logic [NB-1:0] exp_n(input logic [WB-1:0] w);
    return found_in_time(w) ? w[WB-1:WB-NB] : '0;
  endfunction

  function automatic logic [WB-1:0] mk_w(input logic [7:0] tgt);
    logic [28:0] hi;
    logic [6:0]  mid;
    hi  = 29'($urandom);
    mid = 7'($urandom);
    return {hi, mid, tgt};
  endfunction

  function automatic logic [WB-1:0] next_w();
    int unsigned r;
    if (plan_q.size() > 0) return plan_q.pop_front();
    r = $urandom_range(9);
    case (r)
      0:       return mk_w(8'd0);
      1:       return mk_w(8'd64);
      2:       return mk_w(8'd65);
      3:       return mk_w(8'd63);
      default: return mk_w(8'($urandom_range(30, 1)));
    endcase
  endfunction

  task automatic push_one(input logic [WB-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_one: in_ready=%b, required 1", in_ready);
    end else begin
      in_valid = 1'b1;
      in_w     = w;
      acc_w.push_back(w);
      acc_c.push_back(cyc);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Concurrent producer/consumer checked against the job queue model
  task automatic run_jobs(input int n_push, input int n_pop, input int unsigned valid_pct,
                          input int unsigned ready_pct, input int unsigned budget, output int stalls);
    int unsigned deadline;
    int          st;
    deadline = cyc + budget;
    st = 0;
    fork
      begin : producer
        int            sent;
        bit            have;
        logic [WB-1:0] w;
        sent = 0;
        have = 1'b0;
        w    = '0;
        while (sent < n_push && cyc < deadline) begin
          @(negedge clk);
          if (!have && $urandom_range(99) < valid_pct) begin
            w    = next_w();
            have = 1'b1;
          end
          if (have) begin
            in_valid = 1'b1;
            in_w     = w;
            if (in_ready === 1'b1) begin
              acc_w.push_back(w);
              acc_c.push_back(cyc);
              sent++;
              have = 1'b0;
            end else begin
              st++;
            end
          end else begin
            in_valid = 1'b0;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (n_push > 0) begin
          n_cmp++;
          if (sent < n_push) begin
            n_fail++;
            $display("FAIL push_budget: accepted %0d jobs, required %0d", sent, n_push);
          end
        end
      end
      begin : consumer
        int            got, run_k;
        bit            track, chk_load, prev_v;
        logic [WB-1:0] load_w, p_w, p_sw, w;
        logic [NB-1:0] p_n;
        logic          p_to;
        got = 0; run_k = 0; track = 1'b0; chk_load = 1'b0; prev_v = 1'b0;
        load_w = '0; p_w = '0; p_sw = '0; p_n = '0; p_to = 1'b0;
        while ((got < n_pop || chk_load) && cyc < deadline) begin
          @(negedge clk);
          if (chk_load) begin
            chk_load = 1'b0;
            n_cmp++;
            if (sol_rst_n !== 1'b0 || sol_w !== load_w) begin
              n_fail++;
              $display("FAIL b2b_load: sol_rst_n=%b sol_w=%h, required 0 and %h", sol_rst_n, sol_w, load_w);
            end
          end
          if (sol_rst_n === 1'b0) begin
            track = 1'b1;
            run_k = 0;
          end else if (track && out_valid !== 1'b1) begin
            run_k++;
          end else if (track) begin
            track = 1'b0;
            n_cmp++;
            if (acc_w.size() == 0 || run_k != exp_cyc(acc_w[0])) begin
              n_fail++;
              $display("FAIL run_cycles: got %0d RUN cycles, required %0d", run_k,
                       (acc_w.size() == 0) ? -1 : exp_cyc(acc_w[0]));
            end
          end
          if (prev_v) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_w !== p_w || out_n !== p_n || out_timeout !== p_to ||
                sol_w !== p_sw || sol_rst_n !== 1'b1) begin
              n_fail++;
              $display("FAIL hold: v=%b w=%h n=%h to=%b sol_w=%h, required 1 %h %h %b %h",
                       out_valid, out_w, out_n, out_timeout, sol_w, p_w, p_n, p_to, p_sw);
            end
          end
          prev_v = 1'b0;
          if (got < n_pop && out_valid === 1'b1 && $urandom_range(99) < ready_pct) begin
            out_ready = 1'b1;
            n_cmp++;
            if (acc_w.size() == 0) begin
              n_fail++;
              $display("FAIL result_spurious: out_w=%h, required no result", out_w);
            end else begin
              w = acc_w.pop_front();
              void'(acc_c.pop_front());
              if (out_w !== w || out_n !== exp_n(w) || out_timeout !== exp_to(w)) begin
                n_fail++;
                $display("FAIL result: w=%h n=%h to=%b, required %h %h %b",
                         out_w, out_n, out_timeout, w, exp_n(w), exp_to(w));
              end
`ifdef TRADEOFF_SEQ_STATS_EN
              n_cmp++;
              if (out_cycles !== CW'(exp_cyc(w)) || jobs_done !== 16'(jobs_model)) begin
                n_fail++;
                $display("FAIL stats: out_cycles=%0d jobs_done=%0d, required %0d %0d",
                         out_cycles, jobs_done, exp_cyc(w), jobs_model);
              end
`endif
              jobs_model++;
              got++;
              if (acc_w.size() > 0 && acc_c[0] < cyc) begin
                chk_load = 1'b1;
                load_w   = acc_w[0];
              end
            end
          end else begin
            out_ready = 1'b0;
            if (out_valid === 1'b1) begin
              prev_v = 1'b1;
              p_w = out_w; p_n = out_n; p_to = out_timeout; p_sw = sol_w;
            end
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
        if (n_pop > 0) begin
          n_cmp++;
          if (got < n_pop) begin
            n_fail++;
            $display("FAIL pop_budget: received %0d results, required %0d", got, n_pop);
          end
        end
      end
    join
    stalls = st;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_w = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sol_rst_n !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: v=%b rdy=%b srst=%b busy=%b, required 0 1 0 0",
               out_valid, in_ready, sol_rst_n, busy);
    end
    n_cmp++;
    if (sol_w !== '0 || out_w !== '0 || out_n !== '0 || out_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: sol_w=%h out_w=%h out_n=%h to=%b, required zeros", sol_w, out_w, out_n, out_timeout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || sol_rst_n !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b srst=%b busy=%b v=%b, required 1 1 0 0",
               in_ready, sol_rst_n, busy, out_valid);
    end
  endtask

  task automatic test_single_found();
    logic [WB-1:0] w;
    int            k, st;
    w = {29'h0FFFFFFF, 7'h2A, 8'd50};
    push_one(w);
    n_cmp++;
    if (busy !== 1'b1 || sol_rst_n !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_idle: busy=%b srst=%b v=%b, required 1 1 0", busy, sol_rst_n, out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (sol_rst_n !== 1'b0 || sol_w !== w) begin
      n_fail++;
      $display("FAIL latency_load: srst=%b sol_w=%h, required 0 %h", sol_rst_n, sol_w, w);
    end
    k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 200) begin
      k++;
      @(negedge clk);
    end
    n_cmp++;
    if (k != 50 || out_n !== 29'd268435455 || out_timeout !== 1'b0 || out_w !== w) begin
      n_fail++;
      $display("FAIL single_found: cycles=%0d n=%0d to=%b w=%h, required 50 268435455 0 %h",
               k, out_n, out_timeout, out_w, w);
    end
`ifdef TRADEOFF_SEQ_STATS_EN
    n_cmp++;
    if (out_cycles !== CW'(50)) begin
      n_fail++;
      $display("FAIL single_cycles: out_cycles=%0d, required 50", out_cycles);
    end
`endif
    run_jobs(0, 1, 0, 100, 50, st);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: v=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_timeout();
    int st;
    plan_q.push_back(mk_w(8'd0));
    plan_q.push_back(mk_w(8'd64));
    plan_q.push_back(mk_w(8'd65));
    plan_q.push_back(mk_w(8'd63));
    plan_q.push_back(mk_w(8'd1));
    run_jobs(5, 5, 100, 100, 1500, st);
  endtask

  task automatic test_back_to_back();
    int st;
    for (int i = 0; i < 6; i++) plan_q.push_back(mk_w(8'($urandom_range(20, 10))));
    run_jobs(6, 6, 100, 100, 1000, st);
    n_cmp++;
    if (st == 0) begin
      n_fail++;
      $display("FAIL in_ready_full: in_ready never dropped with 6 jobs offered, required a stall");
    end
  endtask

  task automatic test_stall();
    logic [WB-1:0] a, b, hw;
    logic [NB-1:0] hn;
    int            k, st;
    a = mk_w(8'd5);
    b = mk_w(8'd7);
    out_ready = 1'b0;
    push_one(a);
    push_one(b);
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (out_valid !== 1'b1 || out_w !== a || out_n !== exp_n(a) || out_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_first: v=%b w=%h n=%h to=%b, required 1 %h %h 0", out_valid, out_w, out_n, out_timeout, a, exp_n(a));
    end
    hw = out_w;
    hn = out_n;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_w !== hw || out_n !== hn || sol_w !== a || sol_rst_n !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: v=%b w=%h n=%h sol_w=%h srst=%b, required 1 %h %h %h 1",
                 out_valid, out_w, out_n, sol_w, sol_rst_n, hw, hn, a);
      end
    end
    run_jobs(0, 2, 0, 100, 300, st);
  endtask

  task automatic test_random();
    int st;
    run_jobs(30, 30, 50, 70, 8000, st);
  endtask

  task automatic test_reset_mid_run();
    int st;
    bit bad;
    for (int i = 0; i < 3; i++) plan_q.push_back(mk_w(8'd200));
    run_jobs(3, 0, 100, 0, 100, st);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sol_rst_n !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_sol_follow: sol_rst_n=%b, required 0", sol_rst_n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    acc_w.delete();
    acc_c.delete();
    jobs_model = 0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sol_w !== '0 || sol_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_state: v=%b busy=%b rdy=%b sol_w=%h srst=%b, required 0 0 1 0 1",
               out_valid, busy, in_ready, sol_w, sol_rst_n);
    end
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (busy !== 1'b0 || out_valid !== 1'b0 || sol_rst_n !== 1'b1) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL midrst_stale: a queued job survived reset (busy=%b v=%b), required idle", busy, out_valid);
    end
    plan_q.push_back(mk_w(8'd3));
    run_jobs(1, 1, 100, 100, 200, st);
  endtask

  initial begin
    test_reset();
    test_single_found();
    test_timeout();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
